// File: rtl/elastic_fifo_pkg.sv
// Shared constants and helpers for the elastic FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package elastic_fifo_pkg;

    localparam int MODE_BACKPRESSURE = 0;
    localparam int MODE_DROP         = 1;
    localparam int DROP_COUNT_W      = 16;

    // Saturating increment keeps statistics pinned at all-ones.
    function automatic logic [DROP_COUNT_W-1:0] sat_inc(input logic [DROP_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/elastic_fifo_ram.sv
// Storage array for the elastic FIFO: one write port, one asynchronous read port.
// Latency: write lands on the rising edge, read is combinational.
// Backpressure: none; the controller decides when to write.
module elastic_fifo_ram #(
    parameter int DATA_SIZE  = 16,
    parameter int FIFO_DEPTH = 5,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem [0:FIFO_DEPTH-1];

    // Contents are never reset; the controller's level tracks validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/elastic_fifo.sv
// Circular-buffer FIFO with zero-latency bypass when empty; ELASTIC_FIFO_STATS_EN adds drop_count.
// Latency: 0 cycles when empty (bypass), otherwise head word presented from storage.
// Backpressure: MODE 0 deasserts in_ready when full; MODE 1 always ready and drops on full.
module elastic_fifo
    import elastic_fifo_pkg::*;
#(
    parameter int DATA_SIZE   = 16,
    parameter int FIFO_DEPTH  = 5,
    parameter int MODE        = MODE_BACKPRESSURE,
    parameter int ALMOST_FULL = FIFO_DEPTH - 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_SIZE-1:0]             in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_SIZE-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             almost_full,
    output logic                             overflow,
    input  logic                             overflow_clr
`ifdef ELASTIC_FIFO_STATS_EN
    ,
    output logic [DROP_COUNT_W-1:0]          drop_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(ALMOST_FULL);

    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [LVL_W-1:0]     level_q;
    logic                 overflow_q;
    logic [DATA_SIZE-1:0] rd_data;

    logic empty;
    logic full;
    logic accept;
    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = !rst && ((MODE == MODE_DROP) || !full);

    assign accept = in_valid && in_ready;
    assign push   = accept && !(empty && out_ready);
    assign pop    = out_ready && !empty;

    // A full buffer can still take a word if the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign drop  = (MODE == MODE_DROP) && push && full && !pop;

    assign out_valid   = !rst && (!empty || in_valid);
    assign out_data    = empty ? in_data : rd_data;
    assign level       = level_q;
    assign almost_full = (level_q >= LVL_AF);
    assign overflow    = overflow_q;

    elastic_fifo_ram #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef ELASTIC_FIFO_STATS_EN
    logic [DROP_COUNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            drop_cnt_q <= overflow_clr ? DROP_COUNT_W'(1) : sat_inc(drop_cnt_q);
        end else if (overflow_clr) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
